// File: rtl/rx_serial_to_parallel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_serial_to_parallel_pkg
// Description : Shared PHY definitions. Holds the comma/idle symbol, the
//               receive lane state encoding and the default lock threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_serial_to_parallel_pkg;

    // K28.5 comma/idle symbol, also used by the TX byte-insertion logic
    localparam logic [7:0] PHY_COM_SYMBOL = 8'hBC;

    // Consecutive aligned COM bytes needed before the lane is declared active
    localparam int PHY_LOCK_COUNT = 4;

    // Receive lane alignment state; code 2'b11 is unused
    typedef enum logic [1:0] {
        RX_UNLOCKED = 2'b00,
        RX_ALIGNING = 2'b01,
        RX_LOCKED   = 2'b10
    } rx_state_t;

endpackage : rx_serial_to_parallel_pkg
`default_nettype wire

// File: rtl/rx_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : rx_serial_to_parallel
// Description : Per-lane receive stage. Shifts the MSB-first serial stream
//               into bytes, hunts bit-by-bit for the COM symbol, declares
//               lock after LOCK_COUNT aligned COMs and then delivers every
//               non-COM byte with valid_out and a byte_strobe pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_serial_to_parallel
    import rx_serial_to_parallel_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = PHY_COM_SYMBOL,
    parameter int         LOCK_COUNT = PHY_LOCK_COUNT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam logic [3:0] c_LOCK_COUNT = 4'(LOCK_COUNT);

    rx_state_t  r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;

    logic [7:0] w_sr_next;
    logic       w_is_com;
    logic       w_boundary;
    logic [3:0] w_com_cnt_inc;

    // Next shift-register value is the byte ending with the bit sampled now
    always_comb begin
        w_sr_next     = {r_sr[6:0], data_in};
        w_is_com      = (w_sr_next == COM_SYMBOL);
        w_boundary    = (r_bit_cnt == 3'd7);
        w_com_cnt_inc = r_com_cnt + 4'd1;
    end

    // Shift register, bit counter, alignment FSM and registered outputs
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= RX_UNLOCKED;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_com_cnt   <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            r_sr        <= w_sr_next;
            byte_strobe <= 1'b0;
            case (r_state)
                RX_UNLOCKED: begin
                    // Bit-level hunt: any window matching COM fixes alignment
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            r_state <= RX_LOCKED;
                            active  <= 1'b1;
                        end else begin
                            r_state <= RX_ALIGNING;
                        end
                    end
                end
                RX_ALIGNING: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_com_cnt <= w_com_cnt_inc;
                            if (w_com_cnt_inc == c_LOCK_COUNT) begin
                                r_state <= RX_LOCKED;
                                active  <= 1'b1;
                            end
                        end else begin
                            // Broken COM run: fall back to the bit-level hunt
                            r_state   <= RX_UNLOCKED;
                            r_com_cnt <= 4'd0;
                        end
                    end
                end
                RX_LOCKED: begin
                    // Only boundary bytes are evaluated; straddling COMs are ignored
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        byte_strobe <= 1'b1;
                        if (w_is_com) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= w_sr_next;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= RX_UNLOCKED;
                    r_bit_cnt <= 3'd0;
                    r_com_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule : rx_serial_to_parallel
`default_nettype wire

// File: tb/tb_rx_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_serial_to_parallel
// Description : Self-checking bench for rx_serial_to_parallel. A stream-level
//               reference model predicts outputs after every sampled bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_serial_to_parallel;

    localparam logic [7:0] c_COM  = 8'hBC;
    localparam int         c_LOCK = 4;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    int errors = 0;
    int checks = 0;

    // Reference model state: bit history and alignment anchor
    bit         m_hist[$];
    int         m_t;
    int         m_anchor;
    int         m_seen;
    bit         m_locked;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_active;
    logic       e_strobe;

    rx_serial_to_parallel #(
        .COM_SYMBOL (c_COM),
        .LOCK_COUNT (c_LOCK)
    ) u_dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_t      = 0;
        m_anchor = 0;
        m_seen   = 0;
        m_locked = 0;
        e_data   = 8'h00;
        e_valid  = 1'b0;
        e_active = 1'b0;
        e_strobe = 1'b0;
    endtask

    // Most recent eight received bits, oldest first; bits before reset count as 0
    function automatic logic [7:0] last_byte();
        logic [7:0] v;
        int n;
        v = 8'h00;
        n = m_hist.size();
        for (int k = 0; k < 8; k++) begin
            if (n - 8 + k >= 0) v[7-k] = m_hist[n-8+k];
        end
        return v;
    endfunction

    // Apply the receive rules to one newly sampled bit
    task automatic model_step(input bit b);
        logic [7:0] w;
        m_hist.push_back(b);
        m_t++;
        w = last_byte();
        e_strobe = 1'b0;
        if (m_locked) begin
            if ((m_t - m_anchor) % 8 == 0) begin
                e_strobe = 1'b1;
                if (w != c_COM) begin
                    e_data  = w;
                    e_valid = 1'b1;
                end else begin
                    e_valid = 1'b0;
                end
            end
        end else if (m_seen == 0) begin
            if (w == c_COM) begin
                m_anchor = m_t;
                m_seen   = 1;
                if (c_LOCK == 1) begin
                    m_locked = 1;
                    e_active = 1'b1;
                end
            end
        end else if ((m_t - m_anchor) % 8 == 0) begin
            if (w == c_COM) begin
                m_seen++;
                if (m_seen == c_LOCK) begin
                    m_locked = 1;
                    e_active = 1'b1;
                end
            end else begin
                m_seen = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("data_out",    data_out,          e_data);
        chk("valid_out",   {7'd0, valid_out}, {7'd0, e_valid});
        chk("active",      {7'd0, active},    {7'd0, e_active});
        chk("byte_strobe", {7'd0, byte_strobe}, {7'd0, e_strobe});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},   data_out,            8'h00);
        chk({tag, "_valid"},  {7'd0, valid_out},   8'h00);
        chk({tag, "_active"}, {7'd0, active},      8'h00);
        chk({tag, "_strobe"}, {7'd0, byte_strobe}, 8'h00);
    endtask

    // Drive one bit, let the DUT sample it, then compare against the model
    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) send_bit(v[k]);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            check_zero("in_reset");
        end
        reset   = 1'b1;
        data_in = 1'b0;
        model_reset();
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        model_reset();
        #2;

        // Reset held with toggling input, then idle zeros stay unlocked
        do_reset(3);
        for (int k = 0; k < 10; k++) send_bit(1'b0);
        chk("idle_active", {7'd0, active}, 8'h00);

        // Random offset, four COMs, then a data byte
        for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++) send_byte(c_COM);
        chk("three_com_no_lock", {7'd0, active}, 8'h00);
        send_byte(c_COM);
        chk("lock_on_4th_com", {7'd0, active}, 8'h01);
        chk("lock_com_no_valid", {7'd0, valid_out}, 8'h00);
        send_byte(8'hA5);
        chk("first_data", data_out, 8'hA5);
        chk("first_valid", {7'd0, valid_out}, 8'h01);
        chk("first_strobe", {7'd0, byte_strobe}, 8'h01);
        send_bit(1'b0);
        chk("strobe_one_cycle", {7'd0, byte_strobe}, 8'h00);
        for (int k = 0; k < 7; k++) send_bit(1'b1);
        chk("strobe_period", {7'd0, byte_strobe}, 8'h01);

        // Data byte, COM, data byte while locked: valid 1,0,1 with held data
        send_byte(8'h3F);
        chk("d3f_data", data_out, 8'h3F);
        chk("d3f_valid", {7'd0, valid_out}, 8'h01);
        send_byte(c_COM);
        chk("com_hold_data", data_out, 8'h3F);
        chk("com_valid", {7'd0, valid_out}, 8'h00);
        send_byte(8'hE6);
        chk("de6_data", data_out, 8'hE6);
        chk("de6_valid", {7'd0, valid_out}, 8'h01);

        // COM pattern straddling two data bytes must not realign
        send_byte(8'h5E);
        chk("d5e_data", data_out, 8'h5E);
        send_byte(8'hF0);
        chk("df0_data", data_out, 8'hF0);
        chk("df0_valid", {7'd0, valid_out}, 8'h01);

        // Broken COM run: 3 COMs, a data byte, then a full run of 4
        do_reset(1);
        for (int k = 0; k < 3; k++) send_byte(c_COM);
        send_byte(8'h12);
        chk("broken_run_no_lock", {7'd0, active}, 8'h00);
        for (int k = 0; k < 3; k++) send_byte(c_COM);
        chk("second_run_3", {7'd0, active}, 8'h00);
        send_byte(c_COM);
        chk("second_run_lock", {7'd0, active}, 8'h01);
        send_byte(8'h77);
        chk("after_relock_data", data_out, 8'h77);

        // Asynchronous reset mid-byte while locked
        for (int k = 0; k < 3; k++) send_bit(1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk_32f);
        #1;
        check_zero("async_reset_hold");
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) send_byte(c_COM);
        chk("relock_needs_4", {7'd0, active}, 8'h00);
        send_byte(c_COM);
        chk("relock_done", {7'd0, active}, 8'h01);

        // Randomised traffic: random offsets, COM runs and data bytes
        for (int it = 0; it < 40; it++) begin
            if (it % 10 == 0) do_reset(1);
            for (int k = 0; k < int'($urandom_range(0, 7)); k++)
                send_bit(1'($urandom_range(0, 1)));
            for (int k = 0; k < int'($urandom_range(0, 5)); k++)
                send_byte(c_COM);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                send_byte(8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rx_serial_to_parallel
`default_nettype wire

// File: doc/rx_serial_to_parallel.md
Name: rx_serial_to_parallel

Overview:
- Per-lane receive stage of the PHY; sits directly downstream of one TX lane serial output (data_out_0 or data_out_1).
- Shifts the serial bitstream into bytes and searches bit-by-bit for the COM symbol to find byte alignment.
- Declares lane lock (active) after LOCK_COUNT consecutive aligned COMs, then delivers non-COM bytes with valid.
- The team instantiates one copy per lane, ahead of the lane un-striping / 8-to-32 stage.

Parameters:
- COM_SYMBOL, 8'hBC, K28.5 comma/idle symbol used for alignment and filler.
- LOCK_COUNT, 4, consecutive aligned COM bytes required to assert active (range 1..15).

Ports:
- clk_32f  in  1  serial bit clock; one bit sampled per rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- data_in  in  1  serial bit from the TX lane, MSB first.
- data_out  out  8  last received non-COM byte.
- valid_out  out  1  data_out holds a valid data byte.
- active  out  1  lane locked and aligned.
- byte_strobe  out  1  one-cycle pulse at each byte boundary while locked.

Behaviour:
- Reset values: data_out=8'h00, valid_out=0, active=0, byte_strobe=0, state=UNLOCKED, sr=0, bit_cnt=0, com_cnt=0.
- Shift register: sr_next = {sr[6:0], data_in}; sr <= sr_next on every edge, in all states.
- bit_cnt is 3 bits. It is cleared on alignment; otherwise it increments modulo 8 in ALIGNING and LOCKED.
- A byte boundary is an edge with bit_cnt==7. At that edge, sr_next is the full received byte.
- UNLOCKED:
  - Checks every edge: if sr_next==COM_SYMBOL, then bit_cnt<=0, com_cnt<=1, go to ALIGNING.
  - If LOCK_COUNT==1, go directly to LOCKED and set active=1 instead.
- ALIGNING:
  - Checks at each boundary. If sr_next==COM, com_cnt++.
  - When com_cnt+1==LOCK_COUNT, go to LOCKED and set active<=1 on that same edge.
  - If the byte is not COM, go to UNLOCKED with com_cnt=0. Bit-level search resumes on the next edge.
- LOCKED:
  - At each boundary, byte_strobe<=1; it is 0 on all other edges.
  - Byte != COM: data_out<=sr_next, valid_out<=1.
  - Byte == COM: valid_out<=0 and data_out holds its previous value.
  - data_out and valid_out are stable for the 8 cycles between boundaries.
- Lock is sticky: active stays 1 until reset goes low. There is no loss-of-lock detection in this revision.
- Latency:
  - First data byte: data_out/valid_out update on the edge that samples its 8th bit, so they are visible one cycle after that bit is on data_in.
  - active: rises on the boundary of the LOCK_COUNT-th COM, i.e. 8*(LOCK_COUNT-1) cycles after the first COM's final bit.
- The COM byte that completes lock produces no valid.
- Reset is asynchronous; asserting it mid-byte or mid-lock forces all outputs to their reset values immediately.
- A COM pattern straddling two data bytes while LOCKED is ignored, because only boundaries are evaluated.
- State encoding: 2 bits (UNLOCKED, ALIGNING, LOCKED). The unused code returns to UNLOCKED.

Decomposition:
- Shared PHY package holds:
  - COM_SYMBOL constant (8'hBC), shared with the TX byte-insertion logic.
  - The rx lane state enum (UNLOCKED/ALIGNING/LOCKED).
  - The default LOCK_COUNT.
- No sub-module is needed. The shift register, bit counter and FSM stay in one module of about 150 lines.

Test Plan:
- Reset low 3 cycles with data_in toggling -> all outputs 0; state stays UNLOCKED after release with data_in=0.
- 3 random bits, then 4x 8'hBC, then 8'hA5 -> active=1 on the 4th BC's last-bit edge; data_out=8'hA5 and valid_out=1 after the A5 final bit; byte_strobe pulses every 8 cycles.
- 3x BC, then 8'h12, then 4x BC -> no lock after the 3 BCs; FSM returns to UNLOCKED at 12; active=1 only after the second BC group.
- Locked, then send 8'h3F, BC, 8'hE6 -> valid_out 1,0,1; data_out 3F, 3F (held), E6.
- Locked with data 8'h5E,8'hF0, which form bits …10111100… across the boundary -> no realignment; bytes 5E and F0 delivered intact.
- Locked stream, reset pulled low mid-byte for 1 cycle -> outputs clear immediately; relock requires 4 fresh BCs.
